pipeline_hazard_ctrl: RTL and testbench
=======================================

# pipeline_hazard_ctrl

Central stall/flush sequencer for the five-stage pipeline. It drives the enable and synchronous-clear (`en`/`sRST`) inputs of the IF/ID, ID/EX, EX/MEM and MEM/WB latches and the PC enable. Its decisions come from instruction/data memory hits, load-use hazards, taken branches/jumps and the halt bit travelling through EX/MEM. A small FSM tracks outstanding data-memory accesses and the terminal halt condition.

## Interface
Parameters
- `REGW`, 5, register-select width (matches `regbits_t`)

Ports
- `CLK` in 1 — pipeline clock; all state changes on rising edge
- `sRST` in 1 — synchronous, active-high reset
- `ihit` in 1 — instruction memory returned valid instruction this cycle
- `dhit` in 1 — data memory completed access this cycle
- `mem_dREN` in 1 — EX/MEM latch `dmemREN_l`
- `mem_dWEN` in 1 — EX/MEM latch `dmemWEN_l`
- `mem_hlt` in 1 — EX/MEM latch `hlt_l`
- `ex_dREN` in 1 — ID/EX latch load flag
- `ex_wsel` in REGW — ID/EX latch destination register
- `id_rs`, `id_rt` in REGW each — IF/ID source registers
- `ex_pcsrc` in 1 — branch taken / jump resolved in EX
- `pc_en` out 1 — PC update enable
- `ifid_en`, `idex_en`, `exmem_en`, `memwb_en` out 1 each — latch enables
- `ifid_flush`, `idex_flush`, `exmem_flush`, `memwb_flush` out 1 each — latch synchronous clears (to `sRST` of each latch)
- `halt` out 1 — registered, sticky processor halt
- `stall_cnt` out 32 — stall-cycle counter (only with `PIPE_STALL_CNT_EN`)

## Operation
- FSM states: RUN, DWAIT, HALTED. Reset state RUN.
- `dreq` = `mem_dREN | mem_dWEN`. Data stall `dstall` = `dreq & ~dhit`.
- `luse` = `ex_dREN & (ex_wsel != 0) & (ex_wsel == id_rs | ex_wsel == id_rt)`.
- Priority, highest first, evaluated every cycle in RUN/DWAIT:
  1. `dstall`: all enables 0, all flushes 0 (full freeze). RUN→DWAIT.
  2. `mem_hlt` (no dstall): `pc_en`=0; `ifid_flush`=`idex_flush`=1; `exmem_en`=`memwb_en`=1. Next state HALTED.
  3. `ex_pcsrc`: `pc_en`=1; `ifid_flush`=`idex_flush`=1; downstream enabled. Overrides `luse` and `~ihit`.
  4. `luse`: `pc_en`=0, `ifid_en`=0, `idex_flush`=1 (bubble); `exmem_en`=`memwb_en`=1.
  5. `~ihit`: `pc_en`=0, `ifid_flush`=1; other stages advance.
  6. Otherwise all enables 1, flushes 0.
- DWAIT: freeze while `~dhit`; on `dhit` apply rules 2–6 and return to RUN.
- HALTED: all enables 0, all flushes 0, `halt`=1. Exit only via `sRST`.
- Flush and enable to the same latch are never both 1, except that a flush is always honoured by the latch regardless of `en`.

## Timing
- Enables/flushes are combinational from inputs and current state (same-cycle decision); state, `halt` and `stall_cnt` are registered.
- `halt` rises the cycle after `mem_hlt` is accepted (the edge that moves halt into MEM/WB).
- `dhit` in the same cycle as `dreq` causes no stall and no DWAIT entry.
- Reset: while `sRST`=1, all enables 0, all flushes 1, `halt`=0, `stall_cnt`=0. The next state is RUN, and reset mid-DWAIT or in HALTED takes effect on the same edge.
- `dstall` with `mem_hlt` simultaneously: freeze wins; halt is processed after `dhit`.

## Configuration
- `PIPE_STALL_CNT_EN` defined: `stall_cnt` exists. It increments by 1 (wrapping at 2^32) on every edge where `pc_en`=0 and state≠HALTED and `sRST`=0.
- Undefined: the `stall_cnt` port and counter are absent; all other behaviour is identical.

## Test plan
- Reset, then `ihit`=1 with no hazards → all enables 1, flushes 0, `halt`=0, `stall_cnt`=0.
- `mem_dREN`=1, `dhit`=0 for 3 cycles then 1 → 3 cycles all enables 0 (state DWAIT). On the 4th cycle all enables 1, state RUN, and `stall_cnt`=3.
- `ex_dREN`=1, `ex_wsel`=8, `id_rt`=8 → `pc_en`=0, `ifid_en`=0, `idex_flush`=1. Repeating with `ex_wsel`=0 → no stall.
- `luse` and `ex_pcsrc` together → `pc_en`=1, `ifid_flush`=`idex_flush`=1, `ifid_en` unaffected by luse.
- `mem_hlt`=1 → that cycle `pc_en`=0 and `exmem_en`=`memwb_en`=1. Next cycle `halt`=1 and all enables 0, held for 10 cycles. `sRST` pulse → `halt`=0.
- `sRST` asserted during DWAIT → next cycle RUN, no freeze when `dreq`=0.

Source files
------------

// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl: stall/flush sequencer for the five-stage pipeline latches and PC.
// Ports: CLK/sRST (sync active-high reset); ihit, dhit memory handshakes; mem_dREN/mem_dWEN/mem_hlt
// from EX/MEM; ex_dREN/ex_wsel from ID/EX; id_rs/id_rt from IF/ID; ex_pcsrc taken branch/jump.
// Outputs: pc_en, per-latch enables and flushes (combinational), halt (sticky, from FSM state),
// stall_cnt (only when PIPE_STALL_CNT_EN is defined).
module pipeline_hazard_ctrl #(
  parameter int REGW = 5
) (
  input  logic            CLK,
  input  logic            sRST,
  input  logic            ihit,
  input  logic            dhit,
  input  logic            mem_dREN,
  input  logic            mem_dWEN,
  input  logic            mem_hlt,
  input  logic            ex_dREN,
  input  logic [REGW-1:0] ex_wsel,
  input  logic [REGW-1:0] id_rs,
  input  logic [REGW-1:0] id_rt,
  input  logic            ex_pcsrc,
  output logic            pc_en,
  output logic            ifid_en,
  output logic            idex_en,
  output logic            exmem_en,
  output logic            memwb_en,
  output logic            ifid_flush,
  output logic            idex_flush,
  output logic            exmem_flush,
  output logic            memwb_flush,
  output logic            halt
`ifdef PIPE_STALL_CNT_EN
  , output logic [31:0]   stall_cnt
`endif
);
  typedef enum logic [1:0] {RUN, DWAIT, HALTED} state_t;
  state_t state;
  logic frz, act, luse, hl, br, lu, mi;
  // In DWAIT the EX/MEM latch is frozen, so waiting on dhit alone keeps the freeze coherent
  assign frz  = ((mem_dREN | mem_dWEN) & ~dhit) | ((state == DWAIT) & ~dhit);
  assign act  = ~sRST & (state != HALTED) & ~frz;
  assign luse = ex_dREN & (ex_wsel != '0) & ((ex_wsel == id_rs) | (ex_wsel == id_rt));
  assign hl   = act & mem_hlt;
  assign br   = act & ~mem_hlt & ex_pcsrc;
  assign lu   = act & ~mem_hlt & ~ex_pcsrc & luse;
  assign mi   = act & ~mem_hlt & ~ex_pcsrc & ~luse & ~ihit;
  assign pc_en       = act & ~hl & ~lu & ~mi;
  assign ifid_en     = act & ~hl & ~br & ~lu & ~mi;
  assign idex_en     = act & ~hl & ~br & ~lu;
  assign exmem_en    = act;
  assign memwb_en    = act;
  assign ifid_flush  = sRST | hl | br | mi;
  assign idex_flush  = sRST | hl | br | lu;
  assign exmem_flush = sRST;
  assign memwb_flush = sRST;
  assign halt        = state == HALTED;
  always_ff @(posedge CLK)
    if (sRST) state <= RUN;
    else if (state != HALTED) state <= frz ? DWAIT : hl ? HALTED : RUN;
`ifdef PIPE_STALL_CNT_EN
  always_ff @(posedge CLK)
    if (sRST) stall_cnt <= '0;
    else if (~pc_en && state != HALTED) stall_cnt <= stall_cnt + 32'd1;
`endif
endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// tb_pipeline_hazard_ctrl: scoreboard bench for pipeline_hazard_ctrl.
module tb_pipeline_hazard_ctrl;
  logic clk, srst, ihit, dhit, mem_dren, mem_dwen, mem_hlt, ex_dren, ex_pcsrc;
  logic [4:0] ex_wsel, id_rs, id_rt;
  logic pc_en, ifid_en, idex_en, exmem_en, memwb_en;
  logic ifid_flush, idex_flush, exmem_flush, memwb_flush, halt;
  logic [9:0] obs, e;
  logic [9:0] q[$];
  int errors = 0, checks = 0;
  // {pc,ifid,idex,exmem,memwb enables, ifid,idex,exmem,memwb flushes, halt}
  localparam logic [9:0] V_RUN = 10'b11111_0000_0, V_FRZ = 10'b00000_0000_0,
    V_RST = 10'b00000_1111_0, V_LU = 10'b00011_0100_0, V_BR = 10'b10011_1100_0,
    V_HLT = 10'b00011_1100_0, V_MI = 10'b00111_1000_0, V_HALTED = 10'b00000_0000_1;
`ifdef PIPE_STALL_CNT_EN
  logic [31:0] stall_cnt;
`endif
  pipeline_hazard_ctrl #(.REGW(5)) dut (
    .CLK(clk), .sRST(srst), .ihit(ihit), .dhit(dhit), .mem_dREN(mem_dren), .mem_dWEN(mem_dwen),
    .mem_hlt(mem_hlt), .ex_dREN(ex_dren), .ex_wsel(ex_wsel), .id_rs(id_rs), .id_rt(id_rt),
    .ex_pcsrc(ex_pcsrc), .pc_en(pc_en), .ifid_en(ifid_en), .idex_en(idex_en),
    .exmem_en(exmem_en), .memwb_en(memwb_en), .ifid_flush(ifid_flush),
    .idex_flush(idex_flush), .exmem_flush(exmem_flush), .memwb_flush(memwb_flush),
    .halt(halt)
`ifdef PIPE_STALL_CNT_EN
    , .stall_cnt(stall_cnt)
`endif
  );
  assign obs = {pc_en, ifid_en, idex_en, exmem_en, memwb_en,
                ifid_flush, idex_flush, exmem_flush, memwb_flush, halt};
  initial clk = 0;
  always #5 clk = ~clk;
  task automatic idle();
    srst = 0; ihit = 1; dhit = 0; mem_dren = 0; mem_dwen = 0; mem_hlt = 0;
    ex_dren = 0; ex_pcsrc = 0; ex_wsel = 0; id_rs = 0; id_rt = 0;
  endtask
  task automatic nxt();
    @(posedge clk);
    #1;
  endtask
  task automatic rst_pulse();
    idle(); srst = 1; nxt(); srst = 0;
  endtask
  task automatic test_reset();
    idle(); srst = 1; nxt();
    q.push_back(V_RST);
    @(negedge clk); e = q.pop_front(); checks++;
    if (obs !== e) begin errors++; $display("FAIL reset_hold got=%b exp=%b", obs, e); end
    srst = 0;
    q.push_back(V_RUN);
    @(negedge clk); e = q.pop_front(); checks++;
    if (obs !== e) begin errors++; $display("FAIL reset_run got=%b exp=%b", obs, e); end
`ifdef PIPE_STALL_CNT_EN
    checks++;
    if (stall_cnt !== 32'd0) begin errors++; $display("FAIL reset_cnt got=%0d exp=0", stall_cnt); end
`endif
    nxt();
  endtask
  task automatic test_dstall();
    rst_pulse(); idle(); mem_dren = 1;
    for (int i = 0; i < 4; i++) begin
      dhit = (i == 3);
      q.push_back(i < 3 ? V_FRZ : V_RUN);
      @(negedge clk); e = q.pop_front(); checks++;
      if (obs !== e) begin errors++; $display("FAIL dstall_c%0d got=%b exp=%b", i, obs, e); end
`ifdef PIPE_STALL_CNT_EN
      if (i == 3) begin
        checks++;
        if (stall_cnt !== 32'd3) begin errors++; $display("FAIL dstall_cnt got=%0d exp=3", stall_cnt); end
      end
`endif
      nxt();
    end
    idle();
  endtask
  task automatic test_luse();
    logic [9:0] tab_e[4];
    tab_e = '{V_LU, V_RUN, V_LU, V_LU};
    for (int i = 0; i < 4; i++) begin
      idle(); ex_dren = 1;
      ex_wsel = (i == 1) ? 5'd0 : 5'd8;
      id_rt = (i == 2) ? 5'd3 : ((i == 1) ? 5'd0 : 5'd8);
      id_rs = (i == 2) ? 5'd8 : 5'd0;
      ihit = (i != 3);
      q.push_back(tab_e[i]);
      @(negedge clk); e = q.pop_front(); checks++;
      if (obs !== e) begin errors++; $display("FAIL luse_%0d got=%b exp=%b", i, obs, e); end
      nxt();
    end
    idle();
  endtask
  task automatic test_branch();
    idle(); ex_dren = 1; ex_wsel = 5'd8; id_rt = 5'd8; ex_pcsrc = 1; ihit = 0;
    q.push_back(V_BR);
    @(negedge clk); e = q.pop_front(); checks++;
    if (obs !== e) begin errors++; $display("FAIL branch_luse got=%b exp=%b", obs, e); end
    nxt();
    idle(); ihit = 0;
    q.push_back(V_MI);
    @(negedge clk); e = q.pop_front(); checks++;
    if (obs !== e) begin errors++; $display("FAIL imiss got=%b exp=%b", obs, e); end
    nxt(); idle();
  endtask
  task automatic test_back_to_back();
    logic [9:0] tab_e[4];
    tab_e = '{V_RUN, V_FRZ, V_RUN, V_RUN};
    for (int i = 0; i < 4; i++) begin
      idle();
      mem_dren = (i == 0); mem_dwen = (i == 1) || (i == 2); dhit = (i != 1);
      q.push_back(tab_e[i]);
      @(negedge clk); e = q.pop_front(); checks++;
      if (obs !== e) begin errors++; $display("FAIL b2b_%0d got=%b exp=%b", i, obs, e); end
      nxt();
    end
    idle();
  endtask
  task automatic test_halt();
    idle(); mem_hlt = 1;
    q.push_back(V_HLT);
    @(negedge clk); e = q.pop_front(); checks++;
    if (obs !== e) begin errors++; $display("FAIL halt_accept got=%b exp=%b", obs, e); end
    nxt(); idle();
    for (int i = 0; i < 10; i++) begin
      ex_pcsrc = i[0]; mem_dren = i[1];
      q.push_back(V_HALTED);
      @(negedge clk); e = q.pop_front(); checks++;
      if (obs !== e) begin errors++; $display("FAIL halted_%0d got=%b exp=%b", i, obs, e); end
      nxt();
    end
    idle(); srst = 1; nxt();
    q.push_back(V_RST);
    @(negedge clk); e = q.pop_front(); checks++;
    if (obs !== e) begin errors++; $display("FAIL halt_reset got=%b exp=%b", obs, e); end
    srst = 0; nxt();
  endtask
  task automatic test_halt_dstall();
    logic [9:0] tab_e[4];
    tab_e = '{V_FRZ, V_FRZ, V_HLT, V_HALTED};
    rst_pulse();
    for (int i = 0; i < 4; i++) begin
      idle();
      mem_hlt = (i < 3); mem_dren = (i < 3); dhit = (i == 2);
      q.push_back(tab_e[i]);
      @(negedge clk); e = q.pop_front(); checks++;
      if (obs !== e) begin errors++; $display("FAIL hlt_dstall_%0d got=%b exp=%b", i, obs, e); end
      nxt();
    end
    rst_pulse(); idle();
  endtask
  task automatic test_reset_in_dwait();
    idle(); mem_dren = 1;
    q.push_back(V_FRZ);
    @(negedge clk); e = q.pop_front(); checks++;
    if (obs !== e) begin errors++; $display("FAIL dwait_enter got=%b exp=%b", obs, e); end
    nxt(); idle(); srst = 1; nxt();
    q.push_back(V_RST);
    @(negedge clk); e = q.pop_front(); checks++;
    if (obs !== e) begin errors++; $display("FAIL dwait_rst got=%b exp=%b", obs, e); end
    srst = 0; nxt();
    q.push_back(V_RUN);
    @(negedge clk); e = q.pop_front(); checks++;
    if (obs !== e) begin errors++; $display("FAIL dwait_exit got=%b exp=%b", obs, e); end
    nxt();
  endtask
  initial begin
    idle();
    test_reset();
    test_dstall();
    test_luse();
    test_branch();
    test_back_to_back();
    test_halt();
    test_halt_dstall();
    test_reset_in_dwait();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
